// File: rtl/snn_pkg.sv
// snn_pkg: shared FSM state type and default sizing for the spike decoder slice.
package snn_pkg;
    localparam int NUM_OUTPUTS_DEF = 100;
    localparam int WINDOW_DEF = 350;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;
endpackage

// File: rtl/spike_decoder_if.sv
// spike_decoder_if: result channel (valid/ready plus winner data) of the spike decoder.
// total_spikes exists only when SPIKE_DECODER_TOTAL_EN is defined.
interface spike_decoder_if import snn_pkg::*; #(
    parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic result_valid;
    logic result_ready;
    logic no_spike;
    logic [$clog2(NUM_OUTPUTS)-1:0] winner_idx;
    logic [CNT_W-1:0] winner_count;
`ifdef SPIKE_DECODER_TOTAL_EN
    logic [CNT_W+$clog2(NUM_OUTPUTS)-1:0] total_spikes;
    modport master (output result_valid, no_spike, winner_idx, winner_count, total_spikes, input result_ready);
    modport slave (input result_valid, no_spike, winner_idx, winner_count, total_spikes, output result_ready);
`else
    modport master (output result_valid, no_spike, winner_idx, winner_count, input result_ready);
    modport slave (input result_valid, no_spike, winner_idx, winner_count, output result_ready);
`endif
endinterface

// File: rtl/spike_counter_bank.sv
// spike_counter_bank: per-neuron saturating spike counters with an indexed read port.
module spike_counter_bank import snn_pkg::*; #(
    parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic [NUM_OUTPUTS-1:0] spike_in,
    input  logic [$clog2(NUM_OUTPUTS)-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data
);
    logic [CNT_W-1:0] cnt [NUM_OUTPUTS];
    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst)
            if (!rst) cnt[i] <= '0;
            else if (clr) cnt[i] <= '0;
            else if (en && spike_in[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
    end
    assign rd_data = cnt[rd_idx];
endmodule

// File: rtl/spike_decoder.sv
// spike_decoder: counts spikes per output neuron over a window, then scans for the winner.
// Optional SPIKE_DECODER_TOTAL_EN adds a total_spikes sum on the result channel.
module spike_decoder import snn_pkg::*; #(
    parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [NUM_OUTPUTS-1:0] spike_in,
    output logic busy,
    spike_decoder_if.master res
);
    localparam int IW = $clog2(NUM_OUTPUTS);
    localparam int TW = $clog2(WINDOW + NUM_OUTPUTS + 1);
    state_t state, state_nx;
    logic [TW-1:0] t;
    logic [IW-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt, rd_data;
    logic clr, count_last, scan_last;
    assign clr = state == IDLE && start;
    assign count_last = t == TW'(WINDOW - 1);
    assign scan_last = t == TW'(NUM_OUTPUTS - 1);
    spike_counter_bank #(.NUM_OUTPUTS(NUM_OUTPUTS), .CNT_W(CNT_W)) u_bank (
        .clk(clk), .rst(rst), .clr(clr), .en(state == COUNT),
        .spike_in(spike_in), .rd_idx(t[IW-1:0]), .rd_data(rd_data)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state == IDLE  ? (start ? COUNT : IDLE) :
                   state == COUNT ? (count_last ? SCAN : COUNT) :
                   state == SCAN  ? (scan_last ? DONE : SCAN) :
                   (res.result_ready ? IDLE : DONE);
    end
    // t counts samples in COUNT, then doubles as the scan index in SCAN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            t <= '0;
            best_idx <= '0;
            best_cnt <= '0;
        end else begin
            t <= ((state == COUNT && !count_last) || (state == SCAN && !scan_last)) ? t + TW'(1) : '0;
            if (clr) begin
                best_idx <= '0;
                best_cnt <= '0;
            end else if (state == SCAN && rd_data > best_cnt) begin
                best_idx <= t[IW-1:0];
                best_cnt <= rd_data;
            end
        end
    always_comb begin
        busy = state != IDLE;
        res.result_valid = state == DONE;
        res.no_spike = state == DONE && best_cnt == '0;
        res.winner_idx = best_idx;
        res.winner_count = best_cnt;
    end
`ifdef SPIKE_DECODER_TOTAL_EN
    logic [CNT_W+IW-1:0] tot;
    always_ff @(posedge clk or negedge rst)
        if (!rst) tot <= '0;
        else if (clr) tot <= '0;
        else if (state == COUNT) tot <= tot + (CNT_W+IW)'($countones(spike_in));
    assign res.total_spikes = tot;
`endif
endmodule

// File: tb/tb_spike_decoder.sv
// tb_spike_decoder: directed and random windows against a count-and-argmax reference model.
module tb_spike_decoder;
    localparam int N = 4;
    localparam int W = 10;
    logic clk = 0, rst = 0, start = 0;
    logic [N-1:0] spike_in = '0;
    logic busy, busy3;
    logic [N-1:0] pat [W];
    int checks = 0, errors = 0;
    int exp_idx, exp_cnt, exp_ns, exp_idx3, exp_cnt3, exp_ns3, exp_tot;

    spike_decoder_if #(.NUM_OUTPUTS(N), .CNT_W(8)) rif ();
    spike_decoder_if #(.NUM_OUTPUTS(N), .CNT_W(3)) rif3 ();
    spike_decoder #(.NUM_OUTPUTS(N), .WINDOW(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .busy(busy), .res(rif.master));
    spike_decoder #(.NUM_OUTPUTS(N), .WINDOW(W), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .busy(busy3), .res(rif3.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Per-neuron totals clipped to the counter range; winner = lowest index holding the maximum.
    function automatic void model(input int w, output int idx, output int cnt, output int ns);
        int c [N];
        int mx = 0;
        for (int i = 0; i < N; i++) begin
            c[i] = 0;
            for (int k = 0; k < W; k++) c[i] += int'(pat[k][i]);
            if (c[i] > (1 << w) - 1) c[i] = (1 << w) - 1;
            if (c[i] > mx) mx = c[i];
        end
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (c[i] == mx) idx = i;
        cnt = mx;
        ns = (mx == 0) ? 1 : 0;
    endfunction

    task automatic run_window(input bit hold);
        int lat;
        model(8, exp_idx, exp_cnt, exp_ns);
        model(3, exp_idx3, exp_cnt3, exp_ns3);
        exp_tot = 0;
        for (int k = 0; k < W; k++) exp_tot += $countones(pat[k]);
        rif.result_ready = !hold;
        rif3.result_ready = !hold;
        @(negedge clk);
        start = 1;
        spike_in = N'($urandom);
        @(negedge clk);
        start = 0;
        lat = 1;
        chk("busy_in_count", busy, 1);
        for (int k = 0; k < W; k++) begin
            spike_in = pat[k];
            @(negedge clk);
            lat++;
        end
        spike_in = N'($urandom);
        while (!rif.result_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            spike_in = N'($urandom);
        end
        chk("latency", lat, 1 + W + N);
        chk("winner_idx", rif.winner_idx, exp_idx);
        chk("winner_count", rif.winner_count, exp_cnt);
        chk("no_spike", rif.no_spike, exp_ns);
        chk("valid3", rif3.result_valid, 1);
        chk("winner_idx3", rif3.winner_idx, exp_idx3);
        chk("winner_count3", rif3.winner_count, exp_cnt3);
        chk("no_spike3", rif3.no_spike, exp_ns3);
`ifdef SPIKE_DECODER_TOTAL_EN
        chk("total_spikes", rif.total_spikes, exp_tot);
        chk("total_spikes3", rif3.total_spikes, exp_tot % 32);
`endif
        if (hold) begin
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                start = (j == 5);
                chk("hold_valid", rif.result_valid, 1);
                chk("hold_idx", rif.winner_idx, exp_idx);
                chk("hold_count", rif.winner_count, exp_cnt);
                chk("hold_no_spike", rif.no_spike, exp_ns);
            end
            rif.result_ready = 1;
            rif3.result_ready = 1;
            start = 1;
        end
        @(negedge clk);
        start = 0;
        chk("valid_after_handshake", rif.result_valid, 0);
        chk("idle_after_handshake", busy, 0);
    endtask

    initial begin
        rif.result_ready = 1;
        rif3.result_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rif.result_valid, 0);
        chk("rst_idx", rif.winner_idx, 0);
        chk("rst_count", rif.winner_count, 0);
        chk("rst_no_spike", rif.no_spike, 0);
        rst = 1;
        @(negedge clk);
        chk("idle_no_start", busy, 0);
        for (int k = 0; k < W; k++) pat[k] = 4'b0100;
        run_window(0);
        // reset lands in the 5th COUNT cycle; the partial window must vanish
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 4; k++) begin
            spike_in = 4'b1111;
            @(negedge clk);
        end
        rst = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rif.result_valid, 0);
        chk("midrst_idx", rif.winner_idx, 0);
        chk("midrst_count", rif.winner_count, 0);
        chk("midrst_no_spike", rif.no_spike, 0);
        @(negedge clk);
        rst = 1;
        begin
            int seen = 0;
            for (int j = 0; j < 40; j++) begin
                spike_in = N'($urandom);
                @(negedge clk);
                if (rif.result_valid || busy) seen++;
            end
            chk("no_result_after_reset", seen, 0);
        end
        for (int k = 0; k < W; k++) pat[k] = (k < 5) ? 4'b1010 : 4'b0000;
        run_window(0);
        for (int k = 0; k < W; k++) pat[k] = 4'b0000;
        run_window(0);
        for (int k = 0; k < W; k++) pat[k] = 4'b0001;
        run_window(0);
        for (int k = 0; k < W; k++) pat[k] = N'($urandom);
        run_window(1);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < W; k++) pat[k] = N'($urandom) & N'($urandom);
            run_window(0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 The parameter NUM_OUTPUTS SHALL default to 100 and SHALL set the number of output neurons observed.
REQ-002 The parameter WINDOW SHALL default to 350 and SHALL set the number of timesteps (clock cycles) in one classification window.
REQ-003 The parameter CNT_W SHALL default to 8 and SHALL set the width of each per-neuron spike counter.
REQ-004 The port clk SHALL be an input of width 1 and SHALL be the single clock.
REQ-005 The port rst SHALL be an input of width 1 and SHALL be the reset, asynchronous and active-low.
REQ-006 The port start SHALL be an input of width 1; a one-cycle pulse SHALL begin a classification window.
REQ-007 The port spike_in SHALL be an input of width NUM_OUTPUTS and SHALL carry the network spike_out vector, one timestep per cycle.
REQ-008 The port result_ready SHALL be an input of width 1 and SHALL be the consumer acceptance signal.
REQ-009 The port busy SHALL be an output of width 1 and SHALL be high in any state other than IDLE.
REQ-010 The port result_valid SHALL be an output of width 1 and SHALL flag that a result is held.
REQ-011 The port winner_idx SHALL be an output of width $clog2(NUM_OUTPUTS) and SHALL give the index of the winning neuron.
REQ-012 The port winner_count SHALL be an output of width CNT_W and SHALL give the spike count of the winning neuron.
REQ-013 The port no_spike SHALL be an output of width 1 and SHALL be high when every counter is zero at the end of the window.

Function
REQ-014 The FSM SHALL have four states, IDLE, COUNT, SCAN and DONE, and the design SHALL enter IDLE out of reset.
REQ-015 A start pulse seen in IDLE SHALL clear all counters and move to COUNT on the next edge; a start pulse seen in any other state SHALL be ignored.
REQ-016 In COUNT the design SHALL sample spike_in on exactly WINDOW consecutive cycles, the first being the cycle after start.
REQ-017 On each sampled cycle, counter[i] SHALL increment when spike_in[i]=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-018 After the WINDOW-th sample the design SHALL enter SCAN, which SHALL compare one counter per cycle, index 0 through NUM_OUTPUTS-1, taking exactly NUM_OUTPUTS cycles.
REQ-019 During SCAN a counter SHALL replace the current best only when it is strictly greater, so that on a tie the lowest index wins.
REQ-020 When every counter is zero, the result SHALL be winner_idx=0, winner_count=0 and no_spike=1.
REQ-021 After the scan the design SHALL enter DONE with result_valid=1; winner_idx, winner_count and no_spike SHALL stay stable until the handshake.
REQ-022 A cycle with result_valid=1 and result_ready=1 SHALL complete the transfer and move to IDLE on that edge.
REQ-023 When result_ready is held high, the latency from the start pulse to the first cycle of result_valid=1 SHALL be exactly 1+WINDOW+NUM_OUTPUTS cycles.
REQ-024 A start pulse in the same cycle as the completing handshake SHALL be ignored; a new window SHALL require start in IDLE.
REQ-025 spike_in SHALL be ignored in IDLE, SCAN and DONE.

Reset
REQ-026 Asserting rst low SHALL, asynchronously: force IDLE, clear all counters, and set busy, result_valid, winner_idx, winner_count and no_spike to 0.
REQ-027 A reset asserted mid-COUNT or mid-SCAN SHALL discard the partial window, and no result SHALL be produced afterwards.

Configuration
REQ-028 With the macro SPIKE_DECODER_TOTAL_EN defined, an output total_spikes of width CNT_W+$clog2(NUM_OUTPUTS) SHALL hold the non-saturating sum of all spikes sampled in the window; it SHALL be valid alongside result_valid and reset to 0.
REQ-029 Without SPIKE_DECODER_TOTAL_EN, the total_spikes port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 A shared package snn_pkg SHALL hold the FSM state enum type and the default NUM_OUTPUTS, WINDOW and CNT_W constants.
REQ-031 One sub-module, spike_counter_bank, SHALL hold the NUM_OUTPUTS saturating counters, with clear/enable/spike_in inputs and an indexed read port used by SCAN.

Verification
REQ-032 The bench SHALL cover: NUM_OUTPUTS=4, WINDOW=10, spike_in=4'b0100 every cycle -> winner_idx=2, winner_count=10, no_spike=0, with result_valid first seen 15 cycles after start.
REQ-033 The bench SHALL cover: neurons 1 and 3 each spiking 5 times -> winner_idx=1 (tie goes to the lower index).
REQ-034 The bench SHALL cover: spike_in=0 for the whole window -> winner_idx=0, winner_count=0, no_spike=1.
REQ-035 The bench SHALL cover: CNT_W=3, WINDOW=10, neuron 0 spiking every cycle -> winner_count=7 (saturated); with SPIKE_DECODER_TOTAL_EN defined -> total_spikes=10.
REQ-036 The bench SHALL cover: result_ready held low for 20 cycles in DONE -> outputs stable and a start pulse ignored; result_ready high -> IDLE on the next cycle.
REQ-037 The bench SHALL cover: rst asserted low in the 5th COUNT cycle -> all outputs 0 immediately, and no result_valid before the next start.
